audio_processing_unit: RTL and testbench

- Sound-effect generator for the VGA dragon game; sits beside the collision detector and the VGA sync generator.
- Turns single-event collision signals into fixed-length square-wave tones.
- Uses the VGA pixel counters (x, y) as its time base: scanlines for pitch, frames for duration.
- Drives a 1-bit PWM/square audio pin.

---
 rtl/audio_processing_unit.sv | 77 +++++++
 tb/tb_audio_processing_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/audio_processing_unit.sv
// audio_processing_unit: collision-triggered square-wave tones timed by VGA x/y (clk, reset, *DragonCollision in, x/y counters in, sound out)
module audio_processing_unit #(
   parameter int PLAYER_HALF = 64,
   parameter int PLAYER_FRAMES = 30,
   parameter int SWORD_HALF = 16,
   parameter int SWORD_FRAMES = 8,
   parameter int SHEEP_HALF = 32,
   parameter int SHEEP_FRAMES = 15
) (
   input logic clk,
   input logic reset,
   input logic SheepDragonCollision,
   input logic SwordDragonCollision,
   input logic PlayerDragonCollision,
   input logic [9:0] x,
   input logic [9:0] y,
   output logic sound
);
   typedef enum logic {IDLE, PLAYING} state_t;
   typedef enum logic [1:0] {NONE, SHEEP, SWORD, PLAYER} effect_t;
   state_t state, state_n;
   effect_t id, id_n, req;
   logic [7:0] lines, lines_n, half;
   logic [5:0] frames, frames_n, load_frames;
   logic tone, tone_n;
   logic [2:0] prev, trig;
   logic line_tick, frame_tick;
   assign line_tick = x == 10'd0;
   assign frame_tick = line_tick && y == 10'd0;
   assign trig = {PlayerDragonCollision, SwordDragonCollision, SheepDragonCollision} & ~prev;
   assign req = trig[2] ? PLAYER : trig[1] ? SWORD : trig[0] ? SHEEP : NONE;
   assign half = id == PLAYER ? 8'(PLAYER_HALF) : id == SWORD ? 8'(SWORD_HALF) : 8'(SHEEP_HALF);
   assign load_frames = req == PLAYER ? 6'(PLAYER_FRAMES) : req == SWORD ? 6'(SWORD_FRAMES) : 6'(SHEEP_FRAMES);
   always_comb begin
      state_n = state;
      id_n = id;
      lines_n = lines;
      tone_n = tone;
      frames_n = frames;
      if (req != NONE && req >= id) begin
         state_n = PLAYING;
         id_n = req;
         frames_n = load_frames;
         lines_n = '0;
         tone_n = 1'b0;
      end else if (state == PLAYING && frame_tick && frames == 6'd1) begin
         state_n = IDLE;
         id_n = NONE;
         frames_n = '0;
         lines_n = '0;
         tone_n = 1'b0;
      end else if (state == PLAYING) begin
         frames_n = frame_tick ? frames - 6'd1 : frames;
         lines_n = line_tick ? (lines == half - 8'd1 ? 8'd0 : lines + 8'd1) : lines;
         tone_n = line_tick && lines == half - 8'd1 ? ~tone : tone;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         id <= NONE;
         lines <= '0;
         frames <= '0;
         tone <= 1'b0;
         sound <= 1'b0;
         prev <= '0;
      end else begin
         state <= state_n;
         id <= id_n;
         lines <= lines_n;
         frames <= frames_n;
         tone <= tone_n;
         sound <= tone_n && state_n == PLAYING;
         prev <= {PlayerDragonCollision, SwordDragonCollision, SheepDragonCollision};
      end
   end
endmodule

// File: tb/tb_audio_processing_unit.sv
// tb_audio_processing_unit: randomized and directed checks of audio_processing_unit against a line/frame counting model
module tb_audio_processing_unit;
   localparam int W = 8;
   localparam int H = 12;
   localparam int FR = W * H;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sheep = 1'b0, sword = 1'b0, player = 1'b0;
   logic [9:0] x = '0, y = '0;
   logic sound;
   int compared = 0, mismatched = 0;
   int eff = 0, nlines = 0, nframes = 0;
   logic [2:0] prev_m = '0;
   logic exp_s = 1'b0;
   always #5 clk = ~clk;
   audio_processing_unit dut (
      .clk(clk), .reset(reset),
      .SheepDragonCollision(sheep), .SwordDragonCollision(sword), .PlayerDragonCollision(player),
      .x(x), .y(y), .sound(sound)
   );
   function automatic int half_of(int k);
      return k == 3 ? 64 : k == 2 ? 16 : 32;
   endfunction
   function automatic int frames_of(int k);
      return k == 3 ? 30 : k == 2 ? 8 : 15;
   endfunction
   task automatic step();
      logic [2:0] col, trig;
      int req;
      col = {player, sword, sheep};
      trig = col & ~prev_m;
      if (reset) begin
         eff = 0; nlines = 0; nframes = 0; prev_m = '0;
      end else begin
         req = trig[2] ? 3 : trig[1] ? 2 : trig[0] ? 1 : 0;
         if (req != 0 && req >= eff) begin
            eff = req; nlines = 0; nframes = 0;
         end else if (eff != 0) begin
            if (x == 0) nlines++;
            if (x == 0 && y == 0) begin
               nframes++;
               if (nframes == frames_of(eff)) eff = 0;
            end
         end
         prev_m = col;
      end
      exp_s = eff != 0 && ((nlines / half_of(eff)) % 2 == 1);
      @(posedge clk);
      #1;
      if (x == W - 1) begin
         x = '0;
         y = (y == H - 1) ? '0 : y + 10'd1;
      end else x = x + 10'd1;
   endtask
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      compared++;
      if (sound !== 1'b0) begin mismatched++; $display("FAIL reset_state sound=%b want=0", sound); end
      reset = 1'b0;
      for (int c = 0; c < 2 * FR; c++) begin
         step();
         compared++;
         if (sound !== exp_s || sound !== 1'b0) begin mismatched++; $display("FAIL idle_quiet c=%0d sound=%b want=0", c, sound); end
      end
   endtask
   task automatic test_sheep();
      bit done = 0;
      for (int c = 0; c < 18 * FR; c++) begin
         sheep = !done && x == 5 && y == 10;
         if (sheep) done = 1;
         step();
         compared++;
         if (sound !== exp_s) begin mismatched++; $display("FAIL sheep c=%0d sound=%b want=%b", c, sound, exp_s); end
      end
      sheep = 1'b0;
      compared++;
      if (!done || eff != 0 || sound !== 1'b0) begin mismatched++; $display("FAIL sheep_end sound=%b want=0 eff=%0d", sound, eff); end
   endtask
   task automatic test_player_hold();
      int highs = 0;
      for (int c = 0; c < 35 * FR; c++) begin
         player = c >= 3 && c < 3 + 3 * FR;
         step();
         highs += sound;
         compared++;
         if (sound !== exp_s) begin mismatched++; $display("FAIL player_hold c=%0d sound=%b want=%b", c, sound, exp_s); end
      end
      compared++;
      if (highs == 0) begin mismatched++; $display("FAIL player_tone highs=%0d want>0", highs); end
   endtask
   task automatic test_preempt();
      for (int c = 0; c < 12 * FR; c++) begin
         sheep = (c >= 2 && c < 6) || (c >= 2 + 60 * W && c < 4 + 60 * W);
         sword = c >= 2 + 40 * W && c < 5 + 40 * W;
         step();
         compared++;
         if (sound !== exp_s) begin mismatched++; $display("FAIL preempt c=%0d sound=%b want=%b eff=%0d", c, sound, exp_s, eff); end
      end
      sheep = 1'b0; sword = 1'b0;
   endtask
   task automatic test_simultaneous();
      for (int c = 0; c < 32 * FR; c++) begin
         {sheep, sword, player} = {3{c == 7}};
         step();
         compared++;
         if (c == 7 && eff != 3) begin mismatched++; $display("FAIL simul_id eff=%0d want=3", eff); end
         if (sound !== exp_s) begin mismatched++; $display("FAIL simultaneous c=%0d sound=%b want=%b", c, sound, exp_s); end
      end
      {sheep, sword, player} = '0;
   endtask
   task automatic test_reset_mid();
      for (int c = 0; c < 45 * FR; c++) begin
         player = c == 1;
         reset = c == 1 + 10 * FR + 20;
         step();
         compared++;
         if (sound !== exp_s) begin mismatched++; $display("FAIL reset_mid c=%0d sound=%b want=%b", c, sound, exp_s); end
         if (c >= 1 + 10 * FR + 20 && sound !== 1'b0) begin mismatched++; $display("FAIL reset_silent c=%0d sound=%b want=0", c, sound); end
      end
      reset = 1'b0; player = 1'b0;
   endtask
   task automatic test_random();
      for (int c = 0; c < 6000; c++) begin
         if ($urandom_range(199) == 0) sheep = ~sheep;
         if ($urandom_range(299) == 0) sword = ~sword;
         if ($urandom_range(499) == 0) player = ~player;
         reset = $urandom_range(1999) == 0;
         step();
         compared++;
         if (sound !== exp_s) begin mismatched++; $display("FAIL random c=%0d sound=%b want=%b", c, sound, exp_s); end
      end
      reset = 1'b0;
   endtask
   initial begin
      test_reset();
      test_sheep();
      test_player_hold();
      test_preempt();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
